// File: rtl/lcd_message_writer_if.sv
// Bus between the LCD message writer and its surroundings: frame input, HD44780 write bus, status flags.
// The writer is the master of the LCD bus; the slave side supplies the message and observes the panel bus.
interface lcd_message_writer_if;
    logic [255:0] message;
    logic         lcd_rs;
    logic         lcd_rw;
    logic         lcd_en;
    logic [7:0]   lcd_data;
    logic         init_done;
    logic         frame_done;

    modport master (
        input  message,
        output lcd_rs, lcd_rw, lcd_en, lcd_data, init_done, frame_done
    );

    modport slave (
        output message,
        input  lcd_rs, lcd_rw, lcd_en, lcd_data, init_done, frame_done
    );
endinterface

// File: rtl/lcd_message_writer.sv
// Refreshes a 16x2 HD44780 panel from a 32-char frame: power-up, init once, then redraw forever.
// state    | meaning
// PWRUP    | idle after reset before the first command
// INIT     | 0x38, 0x0C, 0x06, 0x01 (phase SETUP/PULSE/HOLD per transfer)
// L1ADDR   | command 0x80; its SETUP latches the frame snapshot
// L1CHAR   | chars 0..15 from the snapshot
// L2ADDR   | command 0xC0
// L2CHAR   | chars 16..31 from the snapshot
// GAP      | idle between frames, then back to L1ADDR
module lcd_message_writer #(
    parameter int unsigned POWERUP_CYCLES = 750000,
    parameter int unsigned EN_CYCLES      = 25,
    parameter int unsigned CMD_WAIT       = 2500,
    parameter int unsigned CLEAR_WAIT     = 100000,
    parameter int unsigned FRAME_GAP      = 500000
) (
    input  logic clk,
    input  logic rst_n,
    lcd_message_writer_if.master bus
);

    localparam int unsigned MAX_A   = (POWERUP_CYCLES > CLEAR_WAIT) ? POWERUP_CYCLES : CLEAR_WAIT;
    localparam int unsigned MAX_B   = (FRAME_GAP > CMD_WAIT) ? FRAME_GAP : CMD_WAIT;
    localparam int unsigned MAX_C   = (MAX_A > MAX_B) ? MAX_A : MAX_B;
    localparam int unsigned CNT_MAX = (MAX_C > EN_CYCLES) ? MAX_C : EN_CYCLES;
    localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);

    // Power-up is counted from the first edge after release, hence no -1.
    localparam logic [CNT_W-1:0] LD_PWRUP = CNT_W'(POWERUP_CYCLES);
    localparam logic [CNT_W-1:0] LD_EN    = CNT_W'(EN_CYCLES - 1);
    localparam logic [CNT_W-1:0] LD_CMD   = CNT_W'(CMD_WAIT - 1);
    localparam logic [CNT_W-1:0] LD_CLEAR = CNT_W'(CLEAR_WAIT - 1);
    localparam logic [CNT_W-1:0] LD_GAP   = CNT_W'(FRAME_GAP - 1);

    typedef enum logic [2:0] {
        S_PWRUP, S_INIT, S_L1ADDR, S_L1CHAR, S_L2ADDR, S_L2CHAR, S_GAP
    } state_t;

    typedef enum logic [1:0] {P_SETUP, P_PULSE, P_HOLD} phase_t;

    state_t           r_state;
    phase_t           r_phase;
    logic [CNT_W-1:0] r_cnt;
    logic [1:0]       r_init_idx;
    logic [4:0]       r_char_idx;
    logic [255:0]     r_snap;
    logic             r_rs;
    logic             r_en;
    logic [7:0]       r_data;
    logic             r_init_done;
    logic             r_frame_done;

    state_t           w_nxt_state;
    logic             w_nxt_rs;
    logic [7:0]       w_nxt_data;
    logic [1:0]       w_nxt_init_idx;
    logic [4:0]       w_nxt_char_idx;
    logic             w_frame_end;
    logic             w_cnt_zero;
    logic             w_is_clear;
    logic             w_waiting;

    function automatic logic [7:0] init_cmd(input logic [1:0] idx);
        case (idx)
            2'd0:    init_cmd = 8'h38;
            2'd1:    init_cmd = 8'h0C;
            2'd2:    init_cmd = 8'h06;
            default: init_cmd = 8'h01;
        endcase
    endfunction

    assign w_cnt_zero = (r_cnt == '0);
    assign w_is_clear = (r_state == S_INIT) && (r_init_idx == 2'd3);
    assign w_waiting  = (r_state == S_PWRUP) || (r_state == S_GAP) || (r_phase == P_HOLD);

    // Describes the transfer that follows the current wait.
    always_comb begin
        w_nxt_state    = r_state;
        w_nxt_rs       = 1'b0;
        w_nxt_data     = 8'h00;
        w_nxt_init_idx = r_init_idx;
        w_nxt_char_idx = r_char_idx;
        w_frame_end    = 1'b0;
        case (r_state)
            S_PWRUP: begin
                w_nxt_state    = S_INIT;
                w_nxt_init_idx = 2'd0;
                w_nxt_data     = init_cmd(2'd0);
            end
            S_INIT: begin
                if (r_init_idx == 2'd3) begin
                    w_nxt_state    = S_L1ADDR;
                    w_nxt_char_idx = 5'd0;
                    w_nxt_data     = 8'h80;
                end else begin
                    w_nxt_init_idx = r_init_idx + 2'd1;
                    w_nxt_data     = init_cmd(r_init_idx + 2'd1);
                end
            end
            S_L1ADDR: begin
                w_nxt_state = S_L1CHAR;
                w_nxt_rs    = 1'b1;
            end
            S_L1CHAR: begin
                if (r_char_idx == 5'd15) begin
                    w_nxt_state    = S_L2ADDR;
                    w_nxt_char_idx = 5'd16;
                    w_nxt_data     = 8'hC0;
                end else begin
                    w_nxt_char_idx = r_char_idx + 5'd1;
                    w_nxt_rs       = 1'b1;
                end
            end
            S_L2ADDR: begin
                w_nxt_state = S_L2CHAR;
                w_nxt_rs    = 1'b1;
            end
            S_L2CHAR: begin
                if (r_char_idx == 5'd31) begin
                    w_frame_end = 1'b1;
                end else begin
                    w_nxt_char_idx = r_char_idx + 5'd1;
                    w_nxt_rs       = 1'b1;
                end
            end
            S_GAP: begin
                w_nxt_state    = S_L1ADDR;
                w_nxt_char_idx = 5'd0;
                w_nxt_data     = 8'h80;
            end
            default: ;
        endcase
        if (w_nxt_rs) begin
            w_nxt_data = r_snap[{w_nxt_char_idx, 3'b000} +: 8];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= S_PWRUP;
            r_phase      <= P_HOLD;
            r_cnt        <= LD_PWRUP;
            r_init_idx   <= 2'd0;
            r_char_idx   <= 5'd0;
            r_snap       <= '0;
            r_rs         <= 1'b0;
            r_en         <= 1'b0;
            r_data       <= 8'h00;
            r_init_done  <= 1'b0;
            r_frame_done <= 1'b0;
        end else begin
            r_frame_done <= 1'b0;
            if (w_waiting) begin
                if (!w_cnt_zero) begin
                    r_cnt <= r_cnt - 1'b1;
                end else if (w_frame_end) begin
                    r_state      <= S_GAP;
                    r_cnt        <= LD_GAP;
                    r_frame_done <= 1'b1;
                end else begin
                    r_state    <= w_nxt_state;
                    r_phase    <= P_SETUP;
                    r_rs       <= w_nxt_rs;
                    r_data     <= w_nxt_data;
                    r_init_idx <= w_nxt_init_idx;
                    r_char_idx <= w_nxt_char_idx;
                    if (w_is_clear) begin
                        r_init_done <= 1'b1;
                    end
                end
            end else if (r_phase == P_SETUP) begin
                r_phase <= P_PULSE;
                r_en    <= 1'b1;
                r_cnt   <= LD_EN;
                if (r_state == S_L1ADDR) begin
                    r_snap <= bus.message;
                end
            end else begin
                if (!w_cnt_zero) begin
                    r_cnt <= r_cnt - 1'b1;
                end else begin
                    r_en    <= 1'b0;
                    r_phase <= P_HOLD;
                    r_cnt   <= w_is_clear ? LD_CLEAR : LD_CMD;
                end
            end
        end
    end

    assign bus.lcd_rs     = r_rs;
    assign bus.lcd_rw     = 1'b0;
    assign bus.lcd_en     = r_en;
    assign bus.lcd_data   = r_data;
    assign bus.init_done  = r_init_done;
    assign bus.frame_done = r_frame_done;

endmodule

// File: tb/tb_lcd_message_writer.sv
// Directed bench for lcd_message_writer with shortened timing; a bus monitor checks protocol throughout.
module tb_lcd_message_writer;

    localparam int unsigned T_PWR   = 20;
    localparam int unsigned T_EN    = 2;
    localparam int unsigned T_CMD   = 4;
    localparam int unsigned T_CLEAR = 10;
    localparam int unsigned T_GAP   = 8;

    logic clk;
    logic rst_n;
    lcd_message_writer_if bus();

    lcd_message_writer #(
        .POWERUP_CYCLES(T_PWR),
        .EN_CYCLES     (T_EN),
        .CMD_WAIT      (T_CMD),
        .CLEAR_WAIT    (T_CLEAR),
        .FRAME_GAP     (T_GAP)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;
    int cyc   = -1;
    logic en_prev = 1'b0;
    logic en_cur  = 1'b0;

    logic [255:0] msg_orig;
    logic [255:0] msg_mod;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
        en_prev = en_cur;
        en_cur  = bus.lcd_en;
    endtask

    task automatic wait_en_rise(output int c);
        int budget;
        logic found;
        budget = 400;
        found  = 1'b0;
        c      = -1;
        while (!found && budget > 0) begin
            tick();
            budget--;
            if (en_cur && !en_prev) begin
                found = 1'b1;
                c     = cyc;
            end
        end
        chk("en_rise_seen", 32'(found), 32'd1);
    endtask

    task automatic wait_frame_done(input int exp_cyc);
        int budget;
        logic found;
        budget = 400;
        found  = 1'b0;
        while (!found && budget > 0) begin
            tick();
            budget--;
            if (bus.frame_done) found = 1'b1;
        end
        chk("frame_done_seen", 32'(found), 32'd1);
        chk("frame_done_cycle", 32'(cyc), 32'(exp_cyc));
        tick();
        chk("frame_done_width", 32'(bus.frame_done), 32'd0);
    endtask

    task automatic check_init();
        int highs;
        int c;
        logic [7:0] cmds [4];
        cmds[0] = 8'h38; cmds[1] = 8'h0C; cmds[2] = 8'h06; cmds[3] = 8'h01;
        highs = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (bus.lcd_en) highs++;
        end
        chk("pwrup_en_low", 32'(highs), 32'd0);
        chk("pwrup_init_done", 32'(bus.init_done), 32'd0);
        for (int i = 0; i < 4; i++) begin
            wait_en_rise(c);
            chk("init_cmd_cycle", 32'(c), 32'(21 + 7 * i));
            chk("init_cmd_bus", {23'd0, bus.lcd_rs, bus.lcd_data}, {23'd0, 1'b0, cmds[i]});
        end
        while (cyc < 53) tick();
        chk("init_done_early", 32'(bus.init_done), 32'd0);
        tick();
        chk("init_done_at_54", 32'(bus.init_done), 32'd1);
    endtask

    task automatic check_frame(input logic [255:0] exp_msg, input logic [255:0] apply_msg,
                               input int first_rise);
        int c;
        logic [8:0] exp_bus;
        for (int j = 0; j < 34; j++) begin
            wait_en_rise(c);
            if (j == 0)       exp_bus = {1'b0, 8'h80};
            else if (j <= 16) exp_bus = {1'b1, exp_msg[8*(j-1) +: 8]};
            else if (j == 17) exp_bus = {1'b0, 8'hC0};
            else              exp_bus = {1'b1, exp_msg[8*(j-2) +: 8]};
            chk("xfer_cycle", 32'(c), 32'(first_rise + 7 * j));
            chk("xfer_bus", {23'd0, bus.lcd_rs, bus.lcd_data}, {23'd0, exp_bus});
            if (j == 0) bus.message = apply_msg;
        end
    endtask

    // Protocol monitor
    logic       m_en_prev = 1'b0;
    logic       m_fd_prev = 1'b0;
    logic       m_rs_prev = 1'b0;
    logic [7:0] m_data_prev = 8'h00;
    logic       m_seen = 1'b0;
    logic       m_last_clear = 1'b0;
    int         m_hi = 0;
    int         m_lo = 0;

    always @(negedge clk) begin
        if (!rst_n) begin
            m_en_prev   = 1'b0;
            m_fd_prev   = 1'b0;
            m_rs_prev   = 1'b0;
            m_data_prev = 8'h00;
            m_seen      = 1'b0;
            m_hi        = 0;
            m_lo        = 0;
        end else begin
            chk("mon_rw_zero", 32'(bus.lcd_rw), 32'd0);
            chk("mon_fd_width", 32'(bus.frame_done && m_fd_prev), 32'd0);
            if (bus.lcd_en) begin
                chk("mon_bus_stable", {23'd0, bus.lcd_rs, bus.lcd_data},
                    {23'd0, m_rs_prev, m_data_prev});
                if (!m_en_prev) begin
                    if (m_seen)
                        chk("mon_low_gap", 32'(m_lo >= (m_last_clear ? T_CLEAR + 1 : T_CMD + 1)), 32'd1);
                    m_hi = 1;
                end else begin
                    m_hi++;
                end
            end else begin
                if (m_en_prev) begin
                    chk("mon_en_width", 32'(m_hi), 32'(T_EN));
                    m_seen       = 1'b1;
                    m_last_clear = (m_rs_prev == 1'b0) && (m_data_prev == 8'h01);
                    m_lo         = 0;
                end
                m_lo++;
            end
            m_en_prev   = bus.lcd_en;
            m_fd_prev   = bus.frame_done;
            m_rs_prev   = bus.lcd_rs;
            m_data_prev = bus.lcd_data;
        end
    end

    initial begin
        string s;
        int c;
        s = "NS:0012 SN:0003 EW:0100 WE:0000 ";
        for (int k = 0; k < 32; k++) msg_orig[8*k +: 8] = s[k];
        msg_mod = msg_orig;
        msg_mod[7:0]       = 8'h58;
        msg_mod[8*17 +: 8] = 8'h00;
        msg_mod[8*31 +: 8] = 8'hFF;

        bus.message = msg_orig;
        rst_n = 1'b0;
        #2;
        chk("rst_en", 32'(bus.lcd_en), 32'd0);
        chk("rst_bus", {23'd0, bus.lcd_rs, bus.lcd_data}, 32'd0);
        chk("rst_flags", {30'd0, bus.init_done, bus.frame_done}, 32'd0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        cyc = -1; en_prev = 1'b0; en_cur = 1'b0;

        check_init();
        check_frame(msg_orig, msg_orig, 55);
        wait_frame_done(292);
        check_frame(msg_orig, msg_mod, 301);
        wait_frame_done(538);
        check_frame(msg_mod, msg_mod, 547);
        wait_frame_done(784);

        wait_en_rise(c);
        chk("f4_addr_cycle", 32'(c), 32'd793);
        wait_en_rise(c);
        chk("f4_char0_cycle", 32'(c), 32'd800);
        #1;
        rst_n = 1'b0;
        #1;
        chk("midrst_en", 32'(bus.lcd_en), 32'd0);
        chk("midrst_init_done", 32'(bus.init_done), 32'd0);
        chk("midrst_bus", {23'd0, bus.lcd_rs, bus.lcd_data}, 32'd0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        cyc = -1; en_prev = 1'b0; en_cur = 1'b0;

        check_init();
        wait_en_rise(c);
        chk("rerun_addr_cycle", 32'(c), 32'd55);
        chk("rerun_addr_bus", {23'd0, bus.lcd_rs, bus.lcd_data}, {23'd0, 1'b0, 8'h80});

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
